// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive-frame path.
package uart_rx_pkg;

    // Receive sequencer states; IDLE keeps the all-ones code used by the existing rx logic.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'hF,
        ST_DATA     = 4'h1,
        ST_PARITY   = 4'h2,
        ST_STOP1    = 4'h3,
        ST_STOP2    = 4'h4,
        ST_BRK_WAIT = 4'h5
    } rx_state_e;

    // cfg_data_bits encodings
    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    // Holding-buffer entry: {data[7:0], parity_err, framing_err}
    localparam int FIFO_W = 10;

    // Number of data bits for a cfg_data_bits code.
    function automatic logic [3:0] data_bits_to_n(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            DBITS_5: n = 4'd5;
            DBITS_6: n = 4'd6;
            DBITS_7: n = 4'd7;
            DBITS_8: n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Two-entry holding buffer for received words. A push while full is only
// accepted when a pop happens on the same edge; the caller decides what a
// dropped push means.
module rx_byte_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = FIFO_W
) (
    input  logic         baud_clk,
    input  logic         rx_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push;
    logic         do_pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'(DEPTH));
    // Head reads as zero when nothing is held so the outputs stay clean.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Pointer and occupancy registers.
    always_ff @(posedge baud_clk or posedge rx_rst) begin
        if (rx_rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            // Storage entry register.
            always_ff @(posedge baud_clk or posedge rx_rst) begin
                if (rx_rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive-frame sequencer on the 1x baud clock: start detection, 5-8
// data bits, optional parity, one or two stop bits, break detection, and a
// 2-entry valid/ready holding buffer with a sticky overrun flag.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int   FIFO_DEPTH = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       baud_clk,
    input  logic       rx_rst,
    input  logic       rxd,
    input  logic       rx_en,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_two_stop,
    output logic [7:0] byte_data,
    output logic       byte_perr,
    output logic       byte_ferr,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       err_overrun,
    input  logic       err_clr,
    output logic       break_det,
    output logic       busy
);

    rx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  cfg_bits_q, cfg_bits_d;
    logic        par_en_q, par_en_d;
    logic        par_odd_q, par_odd_d;
    logic        two_stop_q, two_stop_d;
    logic        pe_q, pe_d;
    logic        par_bit_q, par_bit_d;
    logic        overrun_q, overrun_d;
    logic        brk_q, brk_d;

    logic              push;
    logic [FIFO_W-1:0] push_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [FIFO_W-1:0] head;
    logic [3:0]        last_idx;
    logic              line_low;

    assign line_low = (rxd != IDLE_LEVEL);
    assign last_idx = data_bits_to_n(cfg_bits_q) - 4'd1;

    // Frame sequencing: next state, capture and commit.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        cfg_bits_d = cfg_bits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        pe_d       = pe_q;
        par_bit_d  = par_bit_q;
        brk_d      = 1'b0;
        push       = 1'b0;
        push_data  = {shift_q, pe_q, 1'b0};
        case (state_q)
            ST_IDLE: begin
                if (rx_en && line_low) begin
                    cfg_bits_d = cfg_data_bits;
                    par_en_d   = cfg_parity_en;
                    par_odd_d  = cfg_parity_odd;
                    two_stop_d = cfg_two_stop;
                    shift_d    = 8'h00;
                    bit_idx_d  = 3'd0;
                    pe_d       = 1'b0;
                    par_bit_d  = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                shift_d[bit_idx_q] = rxd;
                bit_idx_d          = bit_idx_q + 3'd1;
                if ({1'b0, bit_idx_q} == last_idx) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                pe_d      = (^shift_q) ^ rxd ^ par_odd_q;
                par_bit_d = rxd;
                state_d   = ST_STOP1;
            end
            ST_STOP1: begin
                if (line_low) begin
                    // All-zero frame (parity bit included) with a low stop bit is a break.
                    if ((shift_q == 8'h00) && (!par_en_q || !par_bit_q)) begin
                        brk_d   = 1'b1;
                        state_d = ST_BRK_WAIT;
                    end else begin
                        push      = 1'b1;
                        push_data = {shift_q, pe_q, 1'b1};
                        state_d   = ST_IDLE;
                    end
                end else if (two_stop_q) begin
                    state_d = ST_STOP2;
                end else begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_STOP2: begin
                push      = 1'b1;
                push_data = {shift_q, pe_q, line_low};
                state_d   = ST_IDLE;
            end
            ST_BRK_WAIT: begin
                if (!line_low) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overrun: a push refused by a full buffer with no pop. Set beats clear.
    always_comb begin
        pop       = byte_valid && byte_ready;
        overrun_d = overrun_q;
        if (err_clr) begin
            overrun_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    // Sequencer registers.
    always_ff @(posedge baud_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            cfg_bits_q <= DBITS_8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            pe_q       <= 1'b0;
            par_bit_q  <= 1'b0;
            overrun_q  <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            cfg_bits_q <= cfg_bits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            pe_q       <= pe_d;
            par_bit_q  <= par_bit_d;
            overrun_q  <= overrun_d;
            brk_q      <= brk_d;
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .baud_clk  (baud_clk),
        .rx_rst    (rx_rst),
        .push      (push),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign byte_valid  = !fifo_empty;
    assign byte_data   = head[9:2];
    assign byte_perr   = head[1];
    assign byte_ferr   = head[0];
    assign err_overrun = overrun_q;
    assign break_det   = brk_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames from the test
// plan followed by random frames, checked against a queue-based model.
module tb_uart_rx_frame_ctrl;

    logic       baud_clk = 1'b0;
    logic       rx_rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_en = 1'b1;
    logic [1:0] cfg_data_bits = 2'b11;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_two_stop = 1'b0;
    logic [7:0] byte_data;
    logic       byte_perr;
    logic       byte_ferr;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       err_overrun;
    logic       err_clr = 1'b0;
    logic       break_det;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Model: held words as {data, perr, ferr}, plus the sticky overrun flag.
    logic [9:0] mq[$];
    bit         m_ovr = 1'b0;

    uart_rx_frame_ctrl #(
        .FIFO_DEPTH (2),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .baud_clk       (baud_clk),
        .rx_rst         (rx_rst),
        .rxd            (rxd),
        .rx_en          (rx_en),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .byte_data      (byte_data),
        .byte_perr      (byte_perr),
        .byte_ferr      (byte_ferr),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .err_overrun    (err_overrun),
        .err_clr        (err_clr),
        .break_det      (break_det),
        .busy           (busy)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // Compare the buffer outputs with the model's head.
    task automatic check_head(input string tag);
        check({tag, ".valid"}, byte_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check({tag, ".data"}, byte_data, mq[0][9:2]);
            check({tag, ".perr"}, byte_perr, mq[0][1]);
            check({tag, ".ferr"}, byte_ferr, mq[0][0]);
        end else begin
            check({tag, ".data0"}, byte_data, 8'h00);
        end
        check({tag, ".ovr"}, err_overrun, m_ovr);
    endtask

    task automatic pop_one(input string tag);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        check_head(tag);
    endtask

    task automatic clear_ovr(input string tag);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ovr = 1'b0;
        check_head(tag);
    endtask

    // Send one frame bit per edge and check the outcome the protocol rules predict.
    task automatic send_frame(input logic [7:0] word, input int nb, input bit pen, input bit podd,
                              input bit two, input bit pbit, input bit s1, input bit s2,
                              input bit pop_commit, input bit clr_commit, input int brk_hold,
                              input string tag);
        logic [7:0] w;
        bit         bits[$];
        bit         is_brk;
        int         ones;
        bit         perr;
        bit         ferr;
        w = word & 8'((1 << nb) - 1);
        cfg_data_bits  = 2'(nb - 5);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_two_stop   = two;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(w[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(s1);
        if (s1 && two) bits.push_back(s2);
        is_brk = !s1 && (w == 8'h00) && (!pen || !pbit);
        for (int i = 0; i < bits.size(); i++) begin
            rxd = bits[i];
            if (i == bits.size() - 1) begin
                byte_ready = pop_commit;
                err_clr    = clr_commit;
            end
            tick();
            if (i < bits.size() - 1) begin
                check({tag, ".busy_mid"}, busy, 1'b1);
                check_head({tag, ".mid"});
            end
        end
        byte_ready = 1'b0;
        err_clr    = 1'b0;
        if (pop_commit && mq.size() != 0) void'(mq.pop_front());
        if (clr_commit) m_ovr = 1'b0;
        if (is_brk) begin
            check({tag, ".brk"}, break_det, 1'b1);
            check({tag, ".busy_brk"}, busy, 1'b1);
        end else begin
            ones = $countones(w) + ((pen && pbit) ? 1 : 0);
            perr = pen && (podd ? (ones % 2 == 0) : (ones % 2 == 1));
            ferr = !s1 || (two && !s2);
            if (mq.size() < 2) mq.push_back({w, perr, ferr});
            else m_ovr = 1'b1;
            check({tag, ".brk0"}, break_det, 1'b0);
            check({tag, ".busy_end"}, busy, 1'b0);
        end
        check_head({tag, ".end"});
        if (is_brk) begin
            for (int i = 0; i < brk_hold; i++) begin
                rxd = 1'b0;
                tick();
                check({tag, ".brk_hold_busy"}, busy, 1'b1);
                check({tag, ".brk_hold_pulse"}, break_det, 1'b0);
            end
            rxd = 1'b1;
            tick();
            check({tag, ".brk_exit_busy"}, busy, 1'b0);
            check({tag, ".brk_exit_pulse"}, break_det, 1'b0);
        end
        rxd = 1'b1;
        tick();
        check_head({tag, ".gap"});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".data"}, byte_data, 8'h00);
        check({tag, ".perr"}, byte_perr, 1'b0);
        check({tag, ".ferr"}, byte_ferr, 1'b0);
        check({tag, ".valid"}, byte_valid, 1'b0);
        check({tag, ".ovr"}, err_overrun, 1'b0);
        check({tag, ".brk"}, break_det, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] rw;
        int         rnb;
        bit         rs1;
        bit         rpb;
        bit         rpen;

        // Reset state
        repeat (2) @(posedge baud_clk);
        #1;
        check_all_zero("reset");
        #2 rx_rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // rx_en low blocks start detection
        rx_en = 1'b0;
        rxd   = 1'b0;
        tick();
        tick();
        check("rx_en_off.busy", busy, 1'b0);
        rxd   = 1'b1;
        rx_en = 1'b1;
        tick();

        // 1: 8N1 0xA5
        send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, "t1_8n1_a5");
        pop_one("t1_pop");

        // 2: 7E1 0x41 with wrong then right parity bit
        send_frame(8'h41, 7, 1, 0, 0, 1, 1, 1, 0, 0, 0, "t2_7e1_bad");
        pop_one("t2_pop_a");
        send_frame(8'h41, 7, 1, 0, 0, 0, 1, 1, 0, 0, 0, "t2_7e1_good");
        pop_one("t2_pop_b");

        // 3: overrun with byte_ready low, then clear; set beats clear
        send_frame(8'h11, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, "t3_11");
        send_frame(8'h22, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, "t3_22");
        send_frame(8'h33, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, "t3_33");
        clear_ovr("t3_clr");
        send_frame(8'h44, 8, 0, 0, 0, 0, 1, 1, 0, 1, 0, "t3_44_setwins");
        clear_ovr("t3_clr2");

        // 6: reset mid-frame (buffer full) after data bit 3
        cfg_data_bits = 2'b11;
        cfg_parity_en = 1'b0;
        cfg_two_stop  = 1'b0;
        rxd = 1'b0; tick();
        rxd = 1'b1; tick();
        rxd = 1'b1; tick();
        rxd = 1'b0; tick();
        rxd = 1'b0; tick();
        #2 rx_rst = 1'b1;
        #1;
        mq.delete();
        m_ovr = 1'b0;
        check_all_zero("t6_rst");
        rxd = 1'b1;
        @(negedge baud_clk);
        rx_rst = 1'b0;
        tick();
        check_all_zero("t6_rel");
        send_frame(8'hC3, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, "t6_c3");
        send_frame(8'h01, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, "t6_fill");
        send_frame(8'h02, 8, 0, 0, 0, 0, 1, 1, 1, 0, 0, "t6_full_pop");
        pop_one("t6_pop_a");
        pop_one("t6_pop_b");

        // 4: 14 low edges then high -> one break pulse
        send_frame(8'h00, 8, 0, 0, 0, 0, 0, 1, 0, 0, 4, "t4_break");

        // 5: 8N2 with low second stop, and 5N1 0x1F
        send_frame(8'h5A, 8, 0, 0, 1, 0, 1, 0, 0, 0, 0, "t5_8n2_ferr");
        pop_one("t5_pop_a");
        send_frame(8'hFF, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, "t5_5n1_1f");
        pop_one("t5_pop_b");

        // Random frames
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) pop_one("rnd_pop");
            if ($urandom_range(0, 7) == 0) clear_ovr("rnd_clr");
            rw   = 8'($urandom);
            rnb  = 5 + int'($urandom_range(0, 3));
            rs1  = ($urandom_range(0, 7) != 0);
            rpen = 1'($urandom);
            rpb  = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rw  = 8'h00;
                rs1 = 1'b0;
                rpb = 1'b0;
            end
            send_frame(rw, rnb, rpen, 1'($urandom), 1'($urandom), rpb, rs1,
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)),
                       $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
